rr_locking_arbiter: RTL and testbench

//  N-channel ready/valid arbiter with round-robin fairness and optional burst locking.

---
 rtl/rr_locking_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_locking_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_locking_arbiter.sv
// N-channel ready/valid arbiter: round-robin selection. A winner that asks for a lock
// keeps the grant for COUNT consecutive transfers.
module rr_locking_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int COUNT = 4,
  parameter int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  input  logic [N-1:0]   io_in_lock,
  input  logic [N*W-1:0] io_in_bits,
  output logic [N-1:0]   io_in_ready,
  input  logic           io_out_ready,
  output logic           io_out_valid,
  output logic [W-1:0]   io_out_bits,
  output logic [CW-1:0]  io_chosen,
  output logic           io_locked,
  output logic           io_fire
);

  localparam int BW = $clog2(COUNT) + 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
  localparam logic [BW-1:0] FINAL_BEAT = BW'(COUNT - 1);

  logic [CW-1:0] last_grant_q, last_grant_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic [CW-1:0] chosen;
  logic [CW-1:0] pick_hi, pick_lo;
  logic          found_hi, found_lo;
  logic          fire;

  // Descending scan: the last hit is the lowest index, either above last_grant or overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (io_in_valid[i]) begin
        pick_lo  = CW'(i);
        found_lo = 1'b1;
        if (CW'(i) > last_grant_q) begin
          pick_hi  = CW'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (locked_q)      chosen = lock_idx_q;
    else if (found_hi) chosen = pick_hi;
    else if (found_lo) chosen = pick_lo;
    else               chosen = last_grant_q;
  end

  // Handshake: a beat transfers on a cycle where io_out_valid and io_out_ready are both high;
  // only the chosen channel ever sees ready, so a producer's beat moves only when it is granted.
  always_comb begin
    io_out_bits = '0;
    io_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (chosen == CW'(i)) begin
        io_out_bits    = io_in_bits[i*W +: W];
        io_in_ready[i] = io_out_ready;
      end
    end
  end

  assign io_out_valid = io_in_valid[chosen];
  assign fire         = io_out_valid & io_out_ready;
  assign io_fire      = fire;
  assign io_chosen    = chosen;
  assign io_locked    = locked_q;

  always_comb begin
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    lock_idx_d   = lock_idx_q;
    beat_cnt_d   = beat_cnt_q;
    if (fire) begin
      if (locked_q) begin
        if (beat_cnt_q == FINAL_BEAT) begin
          locked_d   = 1'b0;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end else begin
        last_grant_d = chosen;
        // The first beat of a burst counts as beat 1.
        if (io_in_lock[chosen] && (COUNT > 1)) begin
          locked_d   = 1'b1;
          lock_idx_d = chosen;
          beat_cnt_d = BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LAST_IDX;
      locked_q     <= 1'b0;
      lock_idx_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_idx_q   <= lock_idx_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_locking_arbiter.sv
// Bench for rr_locking_arbiter: a COUNT=4 and a COUNT=1 instance share stimulus and are
// compared every cycle against a circular-search reference model.
module tb_rr_locking_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_lock;
  logic [N*W-1:0] in_bits;
  logic           out_ready;

  logic [N-1:0] rdy0, rdy1;
  logic         ov0, ov1, lk0, lk1, f0, f1;
  logic [W-1:0] ob0, ob1;
  logic [1:0]   ch0, ch1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state per instance: grant pointer, lock owner, beats still owed.
  int m_ptr[2];
  int m_lch[2];
  int m_left[2];
  bit m_on[2];
  int m_count[2] = '{4, 1};

  always #5 clk = ~clk;

  rr_locking_arbiter #(.N(N), .W(W), .COUNT(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_lock(in_lock), .io_in_bits(in_bits),
    .io_in_ready(rdy0), .io_out_ready(out_ready), .io_out_valid(ov0),
    .io_out_bits(ob0), .io_chosen(ch0), .io_locked(lk0), .io_fire(f0)
  );

  rr_locking_arbiter #(.N(N), .W(W), .COUNT(1)) dut1 (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_lock(in_lock), .io_in_bits(in_bits),
    .io_in_ready(rdy1), .io_out_ready(out_ready), .io_out_valid(ov1),
    .io_out_bits(ob1), .io_chosen(ch1), .io_locked(lk1), .io_fire(f1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid channel in circular order after the pointer; the pointer itself if none.
  function automatic int model_pick(input int k);
    if (m_on[k]) return m_lch[k];
    for (int s = 1; s <= N; s++) begin
      if (in_valid[(m_ptr[k] + s) % N]) return (m_ptr[k] + s) % N;
    end
    return m_ptr[k];
  endfunction

  task automatic check_inst(input int k, input int exp_ch);
    int           c;
    logic         ev;
    logic [W-1:0] eb;
    logic [N-1:0] er;
    string        p;
    c  = model_pick(k);
    ev = in_valid[c];
    eb = in_bits[c*W +: W];
    er = out_ready ? N'(1 << c) : '0;
    p  = $sformatf("u%0d_t%0t", k, $time);
    if (exp_ch >= 0) chk({p, "_directed_chosen"}, (k == 0) ? ch0 : ch1, exp_ch);
    chk({p, "_chosen"},    (k == 0) ? ch0 : ch1, c);
    chk({p, "_out_valid"}, (k == 0) ? ov0 : ov1, ev);
    chk({p, "_out_bits"},  (k == 0) ? ob0 : ob1, eb);
    chk({p, "_in_ready"},  (k == 0) ? rdy0 : rdy1, er);
    chk({p, "_locked"},    (k == 0) ? lk0 : lk1, m_on[k]);
    chk({p, "_fire"},      (k == 0) ? f0 : f1, ev & out_ready);
  endtask

  task automatic update_model(input int k);
    int c;
    c = model_pick(k);
    if (reset) begin
      m_ptr[k] = N - 1;
      m_on[k]  = 1'b0;
    end else if (in_valid[c] && out_ready) begin
      if (m_on[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) m_on[k] = 1'b0;
      end else begin
        m_ptr[k] = c;
        if (in_lock[c] && m_count[k] > 1) begin
          m_on[k]   = 1'b1;
          m_lch[k]  = c;
          m_left[k] = m_count[k] - 1;
        end
      end
    end
  endtask

  task automatic cycle(input int e0 = -1, input int e1 = -1);
    @(negedge clk);
    if (chk_en) begin
      check_inst(0, e0);
      check_inst(1, e1);
    end
    @(posedge clk);
    update_model(0);
    update_model(1);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_lock   = 4'b0000;
    in_bits   = 32'h33221100;
    out_ready = 1'b1;
    m_ptr  = '{3, 3};
    m_lch  = '{0, 0};
    m_left = '{0, 0};
    m_on   = '{1'b0, 1'b0};

    // Reset state
    cycle();
    chk_en = 1'b1;
    cycle(0, 0);
    reset = 1'b0;

    // Round robin with everyone valid
    cycle(0, 0); cycle(1, 1); cycle(2, 2); cycle(3, 3); cycle(0, 0);

    // Grant ch2, then wrap to ch0, then ch1
    in_valid = 4'b0100; cycle(2, 2);
    in_valid = 4'b0011; cycle(0, 0); cycle(1, 1);

    // Park pointer on ch0 so ch1 wins the locked burst
    in_valid = 4'b0001; cycle(0, 0);
    in_valid = 4'b1111;
    in_lock  = 4'b0010;
    in_bits[1*W +: W] = 8'hA0; cycle(1, 1);
    in_bits[1*W +: W] = 8'hA1; cycle(1, -1);
    // Backpressure then a dropped valid on the locked channel
    in_bits[1*W +: W] = 8'hA2;
    out_ready = 1'b0; cycle(1, -1); cycle(1, -1); cycle(1, -1);
    out_ready = 1'b1;
    in_valid  = 4'b1101; cycle(1, -1); cycle(1, -1);
    in_valid  = 4'b1111; cycle(1, -1);
    in_bits[1*W +: W] = 8'hA3; cycle(1, -1);
    cycle(2, -1);

    // Reset in the middle of a ch3 burst
    in_lock = 4'b1000; cycle(3, -1); cycle(3, -1);
    reset = 1'b1; cycle(3, -1);
    reset = 1'b0; in_lock = 4'b0000; cycle(0, 0);

    // ch0 requests a lock: COUNT=4 holds ch0, COUNT=1 keeps rotating
    reset = 1'b1; cycle();
    reset = 1'b0; in_lock = 4'b0001;
    cycle(0, 0); cycle(0, 1); cycle(0, 2); cycle(0, 3);
    in_lock = 4'b0000; cycle(1, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = N'($urandom_range(0, (1 << N) - 1));
      in_lock   = N'($urandom_range(0, (1 << N) - 1));
      in_bits   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
